// File: rtl/brew_timer_pkg.sv
// Shared encodings for the brew timer: FSM states, framebuffer lanes, width helper.
package brew_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t PAUSE = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Byte lanes inside one 4-byte pixel slot.
    localparam logic [1:0] LANE_G   = 2'd0;
    localparam logic [1:0] LANE_R   = 2'd1;
    localparam logic [1:0] LANE_B   = 2'd2;
    localparam logic [1:0] LANE_PAD = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brew_timer_if.sv
// Framebuffer byte-write bus: the timer drives, the LED framebuffer listens.
interface brew_timer_if;

    logic [8:0] w_addr;
    logic [7:0] dout;
    logic       write_en;

    modport master (output w_addr, output dout, output write_en);
    modport slave  (input  w_addr, input  dout, input  write_en);

endinterface

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchroniser, then a registered rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic pulse
);

    logic sync0_q;
    logic sync1_q;
    logic prev_q;
    logic pulse_q;

    // Synchronise the raw button and emit one pulse per rising edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync0_q <= d;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            pulse_q <= sync1_q & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/brew_timer.sv
// Brew timer: 1 s prescaler, progress FSM and a free-running LED framebuffer writer.
module brew_timer
    import brew_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 800000,
    parameter int unsigned NUM_LEDS   = 16,
    parameter int unsigned DURATION_S = 256,
    parameter int unsigned LEVEL      = 255
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                sw_start,
    input  logic                sw_stop,
    input  logic                sw_pause,
    brew_timer_if.master        fb,
    output logic                done,
    output logic [1:0]          state_o
);

    localparam int unsigned STEP = DURATION_S / NUM_LEDS;
    localparam int unsigned PW   = cnt_width(CLK_HZ);
    localparam int unsigned SW   = cnt_width(STEP);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SEC_MAX    = SW'(STEP - 1);
    localparam logic [6:0]    LED_MAX    = 7'(NUM_LEDS - 1);
    localparam logic [8:0]    ADDR_MAX   = 9'(4 * NUM_LEDS - 1);
    localparam logic [7:0]    LEVEL_B    = 8'(LEVEL);

    logic ev_start, ev_stop, ev_pause;

    btn_edge u_start (.clk(clk), .nrst(nrst), .d(sw_start), .pulse(ev_start));
    btn_edge u_stop  (.clk(clk), .nrst(nrst), .d(sw_stop),  .pulse(ev_stop));
    btn_edge u_pause (.clk(clk), .nrst(nrst), .d(sw_pause), .pulse(ev_pause));

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [6:0]    led_q, led_d;
    logic          blink_q, blink_d;
    logic [8:0]    w_addr_q, w_addr_d;
    logic [7:0]    dout_q, dout_d;
    logic          write_en_q;
    logic          tick;
    logic [6:0]    pix;
    logic [1:0]    lane;

    assign tick = ((state_q == RUN) || (state_q == DONE)) && (presc_q == PRESC_MAX);

    // FSM, prescaler and progress counters; button events override tick effects.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        led_d   = led_q;
        blink_d = blink_q;

        if ((state_q == RUN) || (state_q == DONE)) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end else if (state_q == IDLE) begin
            presc_d = '0;
        end

        if (tick && (state_q == RUN)) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (led_q == LED_MAX) begin
                    state_d = DONE;
                end else begin
                    led_d = led_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        if (tick && (state_q == DONE)) begin
            blink_d = ~blink_q;
        end

        if (ev_stop) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
            led_d   = '0;
        end else if (ev_start && (state_q == IDLE)) begin
            state_d = RUN;
            presc_d = '0;
            sec_d   = '0;
            led_d   = '0;
        end else if (ev_start && (state_q == PAUSE)) begin
            state_d = RUN;
        end else if (ev_pause && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (ev_pause && (state_q == PAUSE)) begin
            state_d = RUN;
        end

        if (state_d != DONE) begin
            blink_d = 1'b0;
        end
    end

    // Address sweep restarts at 0 on the first write after reset.
    always_comb begin
        if (!write_en_q || (w_addr_q == ADDR_MAX)) begin
            w_addr_d = '0;
        end else begin
            w_addr_d = w_addr_q + 1'b1;
        end
    end

    assign pix  = w_addr_d[8:2];
    assign lane = w_addr_d[1:0];

    // Pixel byte for the address being presented alongside it.
    always_comb begin
        dout_d = '0;
        unique case (lane)
            LANE_G: begin
                if (((state_q == RUN) || (state_q == PAUSE)) && (pix < led_q)) begin
                    dout_d = LEVEL_B;
                end
            end
            LANE_R: begin
                if ((state_q == DONE) && blink_q) begin
                    dout_d = LEVEL_B;
                end
            end
            LANE_B: begin
                // Current pixel is steady in RUN; in PAUSE it shows the frozen prescaler phase.
                if (((state_q == RUN) || ((state_q == PAUSE) && (presc_q >= PRESC_HALF)))
                    && (pix == led_q)) begin
                    dout_d = LEVEL_B;
                end
            end
            LANE_PAD: dout_d = '0;
            default:  dout_d = '0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            led_q      <= '0;
            blink_q    <= 1'b0;
            w_addr_q   <= '0;
            dout_q     <= '0;
            write_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            led_q      <= led_d;
            blink_q    <= blink_d;
            w_addr_q   <= w_addr_d;
            dout_q     <= dout_d;
            write_en_q <= 1'b1;
        end
    end

    assign fb.w_addr   = w_addr_q;
    assign fb.dout     = dout_q;
    assign fb.write_en = write_en_q;
    assign done        = (state_q == DONE);
    assign state_o     = state_q;

endmodule
